// File: rtl/mem_arb_pkg.sv
// Shared state encoding and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection with a registered last-grant pointer.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       any_req,
    output logic       winner
);

    logic last_grant;

    // On contention the requester not served last wins; otherwise the lone requester wins.
    always_comb begin
        any_req = |req;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = ~req[0];
        end
    end

    // Pointer starts at r1 so that r0 wins the first contested grant.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant <= 1'b1;
        end else if (accept && any_req) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between two requesters, with round-robin
// arbitration and a bounded wait for the memory's ready handshake.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  r0_valid_i,
    input  logic                  r0_we_i,
    input  logic [ADDR_WIDTH-1:0] r0_addr_i,
    input  logic [WIDTH-1:0]      r0_wdata_i,
    output logic                  r0_ready_o,
    output logic [WIDTH-1:0]      r0_rdata_o,
    output logic                  r0_err_o,
    input  logic                  r1_valid_i,
    input  logic                  r1_we_i,
    input  logic [ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [WIDTH-1:0]      r1_wdata_i,
    output logic                  r1_ready_o,
    output logic [WIDTH-1:0]      r1_rdata_o,
    output logic                  r1_err_o,
    output logic                  mem_valid_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rdata_i
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_t            state, state_nxt;
    logic                  accept, any_req, winner;
    logic                  owner;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0]      lat_wdata;
    logic [WIDTH-1:0]      rdata_q;
    logic                  err_q;
    logic [7:0]            cnt;

    rr_arbiter2 u_rr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     ({r1_valid_i, r0_valid_i}),
        .accept  (accept),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready_i || (cnt == CNT_LAST)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are captured at grant so requesters may change or drop them afterwards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            owner     <= winner;
            lat_we    <= winner ? r1_we_i    : r0_we_i;
            lat_addr  <= winner ? r1_addr_i  : r0_addr_i;
            lat_wdata <= winner ? r1_wdata_i : r0_wdata_i;
            cnt       <= '0;
        end else if (state == ST_ISSUE) begin
            if (mem_ready_i) begin
                rdata_q <= lat_we ? '0 : mem_rdata_i;
                err_q   <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Memory-side outputs are gated so they read as zero outside ISSUE.
    assign mem_valid_o = (state == ST_ISSUE);
    assign mem_we_o    = mem_valid_o & lat_we;
    assign mem_addr_o  = mem_valid_o ? lat_addr  : '0;
    assign mem_wdata_o = mem_valid_o ? lat_wdata : '0;

    assign r0_ready_o = (state == ST_DONE) && !owner;
    assign r1_ready_o = (state == ST_DONE) &&  owner;
    assign r0_rdata_o = r0_ready_o ? rdata_q : '0;
    assign r1_rdata_o = r1_ready_o ? rdata_q : '0;
    assign r0_err_o   = r0_ready_o & err_q;
    assign r1_err_o   = r1_ready_o & err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of memory words.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 The block SHALL have parameter TIMEOUT, default 15, maximum ISSUE cycles before abort; legal range 2..255.
REQ-005 The block SHALL have clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have rst_i, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have rN_valid_i (N=0,1), input, 1, request from requester N.
REQ-008 The block SHALL have rN_we_i, input, 1, 1=write, 0=read.
REQ-009 The block SHALL have rN_addr_i, input, ADDR_WIDTH, request address.
REQ-010 The block SHALL have rN_wdata_i, input, WIDTH, write data.
REQ-011 The block SHALL have rN_ready_o, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have rN_rdata_o, output, WIDTH, read data, valid while rN_ready_o=1.
REQ-013 The block SHALL have rN_err_o, output, 1, timeout flag, valid while rN_ready_o=1.
REQ-014 The block SHALL have mem_valid_o, mem_we_o, mem_addr_o and mem_wdata_o as outputs of widths 1, 1, ADDR_WIDTH and WIDTH, driving the memory valid_i, write_read_i, addr_i and write_data_i inputs.
REQ-015 The block SHALL have mem_ready_i (1) and mem_rdata_i (WIDTH) as inputs, driven by the memory ready_o and read_data_o outputs.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and DONE.
REQ-017 In IDLE, if any rN_valid_i=1 at a rising edge, the block SHALL latch the winner's we, addr and wdata and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; if one is valid, it wins regardless of history.
REQ-019 In ISSUE, mem_valid_o SHALL be 1 and mem_we_o, mem_addr_o and mem_wdata_o SHALL hold the latched values, stable for the whole state.
REQ-020 In ISSUE, mem_ready_i=1 at an edge SHALL register mem_rdata_i (reads) or 0 (writes), clear err and go to DONE.
REQ-021 The ISSUE cycle counter SHALL be reset to 0 on ISSUE entry; if mem_ready_i=0 at the edge where the counter equals TIMEOUT-1, the block SHALL set err, force rdata to 0 and go to DONE, so ISSUE lasts at most TIMEOUT cycles.
REQ-022 If mem_ready_i=1 on the same edge as the timeout, success SHALL win and err SHALL be 0.
REQ-023 In DONE, the granted rN_ready_o SHALL be 1 for exactly one cycle with rN_rdata_o and rN_err_o; the other requester's outputs SHALL stay 0; the next state SHALL be IDLE.
REQ-024 rN_rdata_o and rN_err_o SHALL be 0 whenever rN_ready_o=0.
REQ-025 mem_valid_o SHALL be 0 outside ISSUE, and mem_ready_i SHALL be ignored outside ISSUE.
REQ-026 Deasserting rN_valid_i after the grant SHALL NOT cancel the transaction.
REQ-027 A requester SHALL hold rN_valid_i until its rN_ready_o; the block does not queue requests.
REQ-028 Minimum latency SHALL be 3 cycles from request edge to rN_ready_o, with memory ready in the first ISSUE cycle.

Reset
REQ-029 rst_i=0 SHALL immediately force IDLE, counter 0, last-grant=r1 (so r0 wins first) and all outputs to 0, including mid-ISSUE.
REQ-030 A transaction interrupted by reset SHALL produce no rN_ready_o pulse.

Structure
REQ-031 The FSM state encodings and the TIMEOUT default SHALL reside in the shared package mem_arb_pkg.
REQ-032 The grant pointer and winner selection SHALL be sub-module rr_arbiter2; the FSM, counter and datapath latches SHALL live in mem_arbiter.

Verification
REQ-033 The bench SHALL cover reset: rst_i=0 with random inputs -> all outputs 0; after release, both valid -> r0 granted.
REQ-034 The bench SHALL cover write/read: r0 writes 0xA5 to addr 3 with memory ready after 2 cycles -> mem_we_o=1, mem_addr_o=3, mem_wdata_o=0xA5, r0_ready_o pulse, r0_err_o=0; r0 then reads addr 3 -> r0_rdata_o=0xA5.
REQ-035 The bench SHALL cover fairness: r0 and r1 both held valid for 6 transactions -> grant order r0,r1,r0,r1,r0,r1.
REQ-036 The bench SHALL cover timeout: TIMEOUT=15, mem_ready_i tied 0, r1 read -> mem_valid_o high exactly 15 cycles, then r1_ready_o=1, r1_err_o=1, r1_rdata_o=0.
REQ-037 The bench SHALL cover the boundary: mem_ready_i=1 on the 15th ISSUE cycle -> err=0 and data returned.
REQ-038 The bench SHALL cover reset mid-ISSUE: rst_i=0 on ISSUE cycle 2 -> mem_valid_o=0 asynchronously; no ready pulse; after release, the next r0 request completes normally.
